// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus an
// iterative 1-bit-per-cycle SLL, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             sltu;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] shifted;
    logic             start_shift;

    assign in_ready = resetn && (state == IDLE);

    assign sum     = src_a + src_b;
    assign diff    = src_a - src_b;
    assign slt     = $signed(src_a) < $signed(src_b);
    assign sltu    = src_a < src_b;
    assign shifted = {shreg[WIDTH-2:0], 1'b0};

    // shamt=0 SLL takes the single-cycle path with result = src_b
    assign start_shift = (alu_control == OP_SLL) && (shamt != '0);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_control)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[MSB] == src_b[MSB]) &&
                          (sum[MSB] != src_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[MSB] != src_b[MSB]) &&
                          (diff[MSB] != src_a[MSB]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
            OP_SLL:  alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (start_shift) begin
                            shreg <= src_b;
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shifted;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        result    <= shifted;
                        zero      <= (shifted == '0);
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, random ops against
// an arithmetic reference model, backpressure and reset-abort sequences.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_control(alu_control),
        .src_a(src_a),
        .src_b(src_b),
        .shamt(shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         output logic [31:0] r, output logic ovf);
        longint s;
        r   = 32'h0;
        ovf = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                r   = a + b;
                ovf = (s > MAXS) || (s < MINS);
            end
            3'b110: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                r   = a - b;
                ovf = (s > MAXS) || (s < MINS);
            end
            3'b111: r = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
            3'b011: r = (longint'(a) < longint'(b)) ? 1 : 0;
            3'b100: r = b << sh;
            default: r = 32'h0;
        endcase
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] er,
                          input logic eo, input int hold);
        int lat;
        int elat;
        elat = (op == 3'b100 && sh != 0) ? 1 + int'(sh) : 1;
        check({name, " in_ready idle"}, {31'b0, in_ready}, 1);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        shamt       = sh;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        alu_control = 3'($urandom);
        src_a       = $urandom;
        src_b       = $urandom;
        shamt       = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            check({name, " busy in_ready"}, {31'b0, in_ready}, 0);
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, elat);
        check({name, " result"}, result, er);
        check({name, " zero"}, {31'b0, zero}, {31'b0, er == 0});
        check({name, " overflow"}, {31'b0, overflow}, {31'b0, eo});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold valid"}, {31'b0, out_valid}, 1);
            check({name, " hold result"}, result, er);
            check({name, " hold in_ready"}, {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " valid drop"}, {31'b0, out_valid}, 0);
    endtask

    initial begin
        logic [31:0] er;
        logic        eo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        int          hi_cnt;

        resetn      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 3'b0;
        src_a       = 32'h0;
        src_b       = 32'h0;
        shamt       = 5'h0;

        tbl.push_back('{3'b010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1});
        tbl.push_back('{3'b110, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b0});
        tbl.push_back('{3'b110, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1});
        tbl.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0});
        tbl.push_back('{3'b011, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0});
        tbl.push_back('{3'b111, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b0});
        tbl.push_back('{3'b011, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0});
        tbl.push_back('{3'b001, 32'hF0F00000, 32'h00000F0F, 5'd0, 32'hF0F00F0F, 1'b0});
        tbl.push_back('{3'b000, 32'hF0F0FFFF, 32'h0FF000FF, 5'd0, 32'h00F000FF, 1'b0});
        tbl.push_back('{3'b101, 32'h12345678, 32'h00000001, 5'd3, 32'h00000000, 1'b0});
        tbl.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0});
        tbl.push_back('{3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b1});
        tbl.push_back('{3'b100, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 1'b0});
        tbl.push_back('{3'b100, 32'h0, 32'h00001234, 5'd0, 32'h00001234, 1'b0});
        tbl.push_back('{3'b100, 32'h0, 32'h00000002, 5'd31, 32'h00000000, 1'b0});
        tbl.push_back('{3'b100, 32'h0, 32'h0000000F, 5'd4, 32'h000000F0, 1'b0});
        tbl.push_back('{3'b100, 32'h0, 32'h80000001, 5'd1, 32'h00000002, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 0);
        check("reset result", result, 0);
        check("reset zero", {31'b0, zero}, 0);
        check("reset overflow", {31'b0, overflow}, 0);
        check("reset in_ready", {31'b0, in_ready}, 0);
        resetn = 1'b1;
        #1;
        check("post-reset in_ready", {31'b0, in_ready}, 1);
        @(negedge clk);

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].sh, tbl[i].res, tbl[i].ovf, i % 3);
        end

        // Backpressure: second op must wait until the first result drains.
        alu_control = 3'b010;
        src_a       = 32'd3;
        src_b       = 32'd4;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_control = 3'b010;
        src_a       = 32'd10;
        src_b       = 32'd20;
        for (int i = 0; i < 5; i++) begin
            check("bp valid", {31'b0, out_valid}, 1);
            check("bp result", result, 32'd7);
            check("bp in_ready", {31'b0, in_ready}, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp drained valid", {31'b0, out_valid}, 0);
        check("bp idle in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second valid", {31'b0, out_valid}, 1);
        check("bp second result", result, 32'd30);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a long shift aborts it silently.
        alu_control = 3'b100;
        src_b       = 32'h1;
        shamt       = 5'd20;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("abort result", result, 0);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) hi_cnt++;
            @(negedge clk);
        end
        check("abort no out_valid", hi_cnt, 0);
        run_op("after abort", 3'b010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom);
            if (i % 4 == 0) b = a;
            if (i % 5 == 0) a = {a[31], 31'h7FFFFFFF} ^ {1'b0, 31'($urandom_range(0, 3))};
            model(op, a, b, sh, er, eo);
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, sh, er, eo,
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute-stage ALU. It consumes the 3-bit `alu_control` code produced by the ALU control decoder, together with two operands and a shift amount. Single-cycle ops complete one cycle after acceptance. SLL runs an iterative 1-bit-per-cycle shifter. Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake toward write-back.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- resetn  input  1  synchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept; high only in IDLE and while resetn=1
- alu_control  input  3  op code (encoding below)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B (value shifted for SLL)
- shamt  input  SHW  shift amount, SLL only
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  registered, result==0
- overflow  output  1  registered signed overflow, ADD/SUB only

## Operation
- alu_control encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT (signed)
  - 011 SLTU (unsigned)
  - 100 SLL (src_b << shamt)
  - 101 reserved: result 0, overflow 0
- Accept: in_valid && in_ready at a rising edge. The op, operands and shamt are captured in that cycle; inputs are ignored at all other times.
- FSM states:
  - IDLE → DONE: accept of a non-SLL op, or SLL with shamt=0. Result is computed and registered on the accept edge.
  - IDLE → SHIFT: accept of SLL with shamt≠0. Load shift reg = src_b, cnt = shamt.
  - SHIFT: each cycle, shift reg <<= 1 (LSB filled with 0) and cnt -= 1. When cnt==1, the final shift is written to result and the state moves to DONE.
  - DONE: out_valid=1; result, zero and overflow held stable. On out_valid && out_ready, go to IDLE.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH.
  - ADD overflow = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB overflow = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - overflow=0 for all other ops.
  - SLT/SLTU result = {WIDTH-1 zeros, lt}. SLT uses a two's-complement compare.
- zero is registered with result (=1 iff result==0), including for SLL and reserved.
- Reset, including mid-SHIFT or mid-DONE: next edge goes to IDLE, any pending result is discarded, and no out_valid is produced for the aborted op.

## Timing
- Reset values: out_valid=0, result=0, zero=0, overflow=0, state=IDLE. in_ready=0 while resetn=0, and in_ready=1 in the first cycle after resetn returns high.
- Latency, with the accept edge at cycle T:
  - non-SLL or shamt=0: out_valid high from cycle T+1.
  - SLL: out_valid high from cycle T+1+shamt (e.g., shamt=31 → T+32).
- in_ready=0 in SHIFT and DONE. A new op can be accepted at the earliest one cycle after the out handshake, so throughput is at most one op per 2 cycles.
- out_valid, once high, stays high with constant result/zero/overflow until out_ready is sampled high (or reset occurs).
- in_valid asserted while in_ready=0 has no effect; the producer must hold it.
- No combinational path exists from in_* to out_*, or from out_ready to in_ready.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001, accepted at T → at T+1: out_valid=1, result=0x80000000, overflow=1, zero=0.
- SUB a=b=0x00000005 → result=0, zero=1, overflow=0. SUB a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1.
- SLT a=0xFFFFFFFF, b=1 → result=1. SLTU with the same operands → result=0. OR 0xF0F0_0000|0x0000_0F0F → 0xF0F00F0F. Op 101 → result 0.
- SLL src_b=1, shamt=31 at T: in_ready=0 during T+1..T+32, out_valid first high at T+32 with result=0x80000000. SLL shamt=0, src_b=0x1234 → result 0x1234 at T+1.
- Backpressure: ADD 3+4, out_ready held low 5 cycles while a second in_valid is driven: result=7 held stable, second op not accepted. out_ready=1 → IDLE, then the second op is accepted on the following edge.
- Reset mid-SHIFT (shamt=20, resetn low at T+5 for one edge): out_valid stays 0 and result=0; the next ADD 1+1 completes normally with result 2.
